// File: rtl/uart_prog_loader.sv
// UART program loader: while Load is high, receives parametrised serial frames on RX,
// validates them and writes accepted words to sequential memory addresses from 0.
module uart_prog_loader #(
   parameter int unsigned BAUD_DIV  = 24,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Load,
   input  logic              RX,
   output logic              Wr_en,
   output logic [ADDR_W-1:0] Wr_addr,
   output logic [DATA_W-1:0] Wr_data,
   output logic [ADDR_W:0]   Byte_count,
   output logic              Busy,
   output logic              Done,
   output logic              FE,
   output logic              PE,
   output logic              Overflow
);
   localparam int unsigned TW    = $clog2(BAUD_DIV);
   localparam int unsigned CW    = 4;
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [TW-1:0] HALF_RELOAD = TW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] FULL_RELOAD = TW'(BAUD_DIV - 1);
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
   localparam logic ODD = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t            state, state_n;
   logic [TW-1:0]     timer, timer_n;
   logic [CW-1:0]     bit_cnt, bit_cnt_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              par_bad, par_bad_n;
   logic              frame_ok, frame_ok_n;
   logic              frame_fe, frame_fe_n;
   logic              rx_meta, rxs;
   logic              load_q;
   logic              tick;

   // RX synchroniser; idles high
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RX;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= S_IDLE;
         timer    <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bad  <= 1'b0;
         frame_ok <= 1'b0;
         frame_fe <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par_bad  <= par_bad_n;
         frame_ok <= frame_ok_n;
         frame_fe <= frame_fe_n;
         Busy     <= (state_n != S_IDLE);
      end
   end

   // Frame receiver: every sample is taken when the bit timer has run down to 0
   always_comb begin
      tick       = (timer == '0);
      state_n    = state;
      timer_n    = tick ? timer : timer - TW'(1);
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      par_bad_n  = par_bad;
      frame_ok_n = 1'b0;
      frame_fe_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (Load && !rxs) begin
               state_n = S_START;
               timer_n = HALF_RELOAD;
            end
         end
         S_START: begin
            if (tick) begin
               if (rxs) begin
                  state_n = S_IDLE;
               end else begin
                  state_n   = S_DATA;
                  timer_n   = FULL_RELOAD;
                  bit_cnt_n = '0;
                  par_bad_n = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_n = {rxs, shreg[DATA_W-1:1]};
               timer_n = FULL_RELOAD;
               if (bit_cnt == CW'(DATA_W - 1)) begin
                  bit_cnt_n = '0;
                  state_n   = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_cnt_n = bit_cnt + CW'(1);
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               par_bad_n = (rxs != ((^shreg) ^ ODD));
               timer_n   = FULL_RELOAD;
               state_n   = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               timer_n = FULL_RELOAD;
               if (!rxs) begin
                  frame_fe_n = 1'b1;
                  state_n    = S_WAIT_HIGH;
               end else if (bit_cnt == CW'(STOP_BITS - 1)) begin
                  frame_ok_n = 1'b1;
                  state_n    = S_IDLE;
               end else begin
                  bit_cnt_n = bit_cnt + CW'(1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (rxs) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      // Leaving the load window abandons any partial frame silently
      if (!Load) begin
         state_n    = S_IDLE;
         frame_ok_n = 1'b0;
         frame_fe_n = 1'b0;
      end
   end

   // Commit stage: a Load rising edge clears status and drops a frame finishing alongside it
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         load_q     <= 1'b0;
         Wr_en      <= 1'b0;
         Wr_addr    <= '0;
         Wr_data    <= '0;
         Byte_count <= '0;
         Done       <= 1'b0;
         FE         <= 1'b0;
         PE         <= 1'b0;
         Overflow   <= 1'b0;
      end else begin
         load_q <= Load;
         Wr_en  <= 1'b0;
         Done   <= load_q & ~Load;
         if (Load && !load_q) begin
            Byte_count <= '0;
            FE         <= 1'b0;
            PE         <= 1'b0;
            Overflow   <= 1'b0;
         end else if (Load) begin
            if (frame_fe) FE <= 1'b1;
            if (frame_ok) begin
               if (par_bad) begin
                  PE <= 1'b1;
               end else if (Byte_count < FULL_COUNT) begin
                  Wr_en      <= 1'b1;
                  Wr_addr    <= Byte_count[ADDR_W-1:0];
                  Wr_data    <= shreg;
                  Byte_count <= Byte_count + (ADDR_W + 1)'(1);
               end else begin
                  Overflow <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: an 8N1 instance and an odd-parity/2-stop/4-deep instance,
// checked against a frame-level scoreboard model.
`timescale 1ns/1ps
module tb_uart_prog_loader;
   localparam int unsigned DW   = 8;
   localparam int unsigned BD_A = 24;
   localparam int unsigned AW_A = 5;
   localparam int unsigned BD_B = 8;
   localparam int unsigned AW_B = 2;
   localparam int unsigned PAR_B = 2;
   localparam int unsigned SB_B = 2;

   typedef struct { int addr; int data; } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   logic load_a, rx_a, load_b, rx_b;
   logic wr_en_a, busy_a, done_a, fe_a, pe_a, ovf_a;
   logic [AW_A-1:0] addr_a;
   logic [DW-1:0]   data_a;
   logic [AW_A:0]   cnt_a;
   logic wr_en_b, busy_b, done_b, fe_b, pe_b, ovf_b;
   logic [AW_B-1:0] addr_b;
   logic [DW-1:0]   data_b;
   logic [AW_B:0]   cnt_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t0_a, t0_b, wr_cyc_a, wr_cyc_b;
   wr_t q_a[$];
   wr_t q_b[$];
   int m_cnt[2];
   bit m_fe[2], m_pe[2], m_ovf[2];
   logic [7:0] norm [6] = '{8'hC0, 8'h40, 8'hA3, 8'hE5, 8'hA0, 8'h00};

   uart_prog_loader #(.BAUD_DIV(BD_A), .DATA_W(DW), .ADDR_W(AW_A), .PARITY(0), .STOP_BITS(1)) dut_a (
      .Clk(clk), .Reset_n(rst_n), .Load(load_a), .RX(rx_a), .Wr_en(wr_en_a), .Wr_addr(addr_a),
      .Wr_data(data_a), .Byte_count(cnt_a), .Busy(busy_a), .Done(done_a), .FE(fe_a), .PE(pe_a),
      .Overflow(ovf_a));

   uart_prog_loader #(.BAUD_DIV(BD_B), .DATA_W(DW), .ADDR_W(AW_B), .PARITY(PAR_B), .STOP_BITS(SB_B)) dut_b (
      .Clk(clk), .Reset_n(rst_n), .Load(load_b), .RX(rx_b), .Wr_en(wr_en_b), .Wr_addr(addr_b),
      .Wr_data(data_b), .Byte_count(cnt_b), .Busy(busy_b), .Done(done_b), .FE(fe_b), .PE(pe_b),
      .Overflow(ovf_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Write monitors against the scoreboard
   always @(negedge clk) begin : mon_a
      wr_t w;
      if (wr_en_a === 1'b1) begin
         wr_cyc_a = cyc;
         check("a_wr_pending", 32'(q_a.size() != 0), 32'd1);
         if (q_a.size() != 0) begin
            w = q_a.pop_front();
            check("a_wr_addr", 32'(addr_a), 32'(w.addr));
            check("a_wr_data", 32'(data_a), 32'(w.data));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      wr_t w;
      if (wr_en_b === 1'b1) begin
         wr_cyc_b = cyc;
         check("b_wr_pending", 32'(q_b.size() != 0), 32'd1);
         if (q_b.size() != 0) begin
            w = q_b.pop_front();
            check("b_wr_addr", 32'(addr_b), 32'(w.addr));
            check("b_wr_data", 32'(data_b), 32'(w.data));
         end
      end
   end

   function automatic int bd_of(input int sel);
      return (sel != 0) ? BD_B : BD_A;
   endfunction

   // Frame-level reference: what happens to the memory and flags for one frame
   task automatic model_frame(input int sel, input int d, input bit bad_par, input bit bad_stop);
      int depth;
      depth = (sel != 0) ? (1 << AW_B) : (1 << AW_A);
      if (bad_stop) m_fe[sel] = 1'b1;
      else if (bad_par) m_pe[sel] = 1'b1;
      else if (m_cnt[sel] < depth) begin
         if (sel != 0) q_b.push_back('{m_cnt[sel], d});
         else q_a.push_back('{m_cnt[sel], d});
         m_cnt[sel]++;
      end else m_ovf[sel] = 1'b1;
   endtask

   task automatic model_clear(input int sel);
      m_cnt[sel] = 0;
      m_fe[sel]  = 1'b0;
      m_pe[sel]  = 1'b0;
      m_ovf[sel] = 1'b0;
   endtask

   task automatic drive_rx(input int sel, input logic v);
      if (sel != 0) rx_b = v;
      else rx_a = v;
   endtask

   task automatic hold_bits(input int sel, input int n);
      repeat (n * bd_of(sel)) @(negedge clk);
   endtask

   // Serial frame driver; called at a falling clock edge, returns at one
   task automatic send_frame(input int sel, input int d, input bit bad_par, input bit bad_stop,
                             input int gap);
      int nstop, ones;
      logic pbit;
      nstop = (sel != 0) ? SB_B : 1;
      if (sel != 0) t0_b = cyc + 1;
      else t0_a = cyc + 1;
      drive_rx(sel, 1'b0);
      hold_bits(sel, 1);
      ones = 0;
      for (int i = 0; i < DW; i++) begin
         drive_rx(sel, ((d >> i) & 1) != 0);
         if (((d >> i) & 1) != 0) ones++;
         hold_bits(sel, 1);
      end
      if (sel != 0) begin
         pbit = (ones % 2) == 0;
         if (bad_par) pbit = ~pbit;
         drive_rx(sel, pbit);
         hold_bits(sel, 1);
      end
      for (int i = 0; i < nstop; i++) begin
         drive_rx(sel, !(bad_stop && i == 0));
         hold_bits(sel, 1);
      end
      drive_rx(sel, 1'b1);
      hold_bits(sel, gap);
   endtask

   task automatic set_load(input int sel, input logic v);
      if (sel != 0) load_b = v;
      else load_a = v;
      if (v) begin
         model_clear(sel);
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic check_done(input string tag, input int sel);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (((sel != 0) ? done_b : done_a) === 1'b1) seen = 1'b1;
      end
      check({tag, "_done"}, 32'(seen), 32'd1);
      if (seen) begin
         @(negedge clk);
         check({tag, "_done_width"}, 32'((sel != 0) ? done_b : done_a), 32'd0);
      end
   endtask

   task automatic check_status(input string tag, input int sel);
      if (sel != 0) begin
         check({tag, "_count"}, 32'(cnt_b), 32'(m_cnt[1]));
         check({tag, "_fe"}, 32'(fe_b), 32'(m_fe[1]));
         check({tag, "_pe"}, 32'(pe_b), 32'(m_pe[1]));
         check({tag, "_ovf"}, 32'(ovf_b), 32'(m_ovf[1]));
         check({tag, "_drained"}, 32'(q_b.size()), 32'd0);
      end else begin
         check({tag, "_count"}, 32'(cnt_a), 32'(m_cnt[0]));
         check({tag, "_fe"}, 32'(fe_a), 32'(m_fe[0]));
         check({tag, "_pe"}, 32'(pe_a), 32'(m_pe[0]));
         check({tag, "_ovf"}, 32'(ovf_a), 32'(m_ovf[0]));
         check({tag, "_drained"}, 32'(q_a.size()), 32'd0);
      end
   endtask

   initial begin
      bit seen;
      bit bs, bp;
      rst_n = 1'b0; load_a = 1'b0; load_b = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
      model_clear(0);
      model_clear(1);
      repeat (3) @(negedge clk);
      check("rst_wr_en", 32'(wr_en_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_addr", 32'(addr_a), 32'd0);
      check_status("rst_a", 0);
      check_status("rst_b", 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal 8N1 load, back-to-back frames
      set_load(0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         model_frame(0, norm[i], 1'b0, 1'b0);
         send_frame(0, norm[i], 1'b0, 1'b0, 0);
         if (i == 0) check("a_latency", 32'(wr_cyc_a - t0_a), 32'(2 + BD_A / 2 + (DW + 1) * BD_A + 1));
      end
      hold_bits(0, 1);
      check_status("normal", 0);
      set_load(0, 1'b0);
      check_done("normal", 0);
      check_status("normal_hold", 0);

      // Framing error, then a good frame, then reload clears
      set_load(0, 1'b1);
      model_frame(0, 8'hA3, 1'b0, 1'b1);
      send_frame(0, 8'hA3, 1'b0, 1'b1, 2);
      model_frame(0, 8'h55, 1'b0, 1'b0);
      send_frame(0, 8'h55, 1'b0, 1'b0, 1);
      check_status("fe", 0);
      set_load(0, 1'b0);
      check_done("fe", 0);
      check_status("fe_hold", 0);
      set_load(0, 1'b1);
      check_status("fe_reload", 0);

      // Short start-bit glitch
      rx_a = 1'b0;
      repeat (5) @(negedge clk);
      rx_a = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (busy_a === 1'b1) seen = 1'b1;
      end
      check("glitch_saw_start", 32'(seen), 32'd1);
      check("glitch_idle", 32'(busy_a), 32'd0);
      check_status("glitch", 0);

      // Random frames with occasional bad stop bits
      for (int i = 0; i < 8; i++) begin
         int d;
         d  = $urandom_range(0, 255);
         bs = ($urandom_range(0, 3) == 0);
         model_frame(0, d, 1'b0, bs);
         send_frame(0, d, 1'b0, bs, bs ? 1 : $urandom_range(0, 2));
      end
      check_status("rand_a", 0);

      // Abort mid data bit
      rx_a = 1'b0;
      repeat (BD_A * 2 + BD_A / 2) @(negedge clk);
      check("abort_busy_before", 32'(busy_a), 32'd1);
      load_a = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'(busy_a), 32'd0);
      check("abort_done", 32'(done_a), 32'd1);
      @(negedge clk);
      check("abort_done_width", 32'(done_a), 32'd0);
      rx_a = 1'b1;
      hold_bits(0, 10);
      check_status("abort", 0);

      // Asynchronous reset mid-frame
      set_load(0, 1'b1);
      model_frame(0, 8'h5A, 1'b0, 1'b0);
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1);
      check("pre_rst_count", 32'(cnt_a), 32'd1);
      rx_a = 1'b0;
      hold_bits(0, 3);
      check("pre_rst_busy", 32'(busy_a), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_count", 32'(cnt_a), 32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      check("mid_rst_addr", 32'(addr_a), 32'd0);
      check("mid_rst_data", 32'(data_a), 32'd0);
      load_a = 1'b0;
      rx_a = 1'b1;
      model_clear(0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done_a === 1'b1 || wr_en_a === 1'b1) seen = 1'b1;
      end
      check("post_rst_no_pulse", 32'(seen), 32'd0);
      check_status("post_rst", 0);

      // Odd parity, two stop bits, 4-deep memory
      set_load(1, 1'b1);
      model_frame(1, 8'hE5, 1'b0, 1'b0);
      send_frame(1, 8'hE5, 1'b0, 1'b0, 1);
      check("b_latency", 32'(wr_cyc_b - t0_b), 32'(2 + BD_B / 2 + (DW + 1 + SB_B) * BD_B + 1));
      model_frame(1, 8'hE5, 1'b1, 1'b0);
      send_frame(1, 8'hE5, 1'b1, 1'b0, 1);
      check_status("parity", 1);
      set_load(1, 1'b0);
      check_done("parity", 1);

      set_load(1, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         model_frame(1, i, 1'b0, 1'b0);
         send_frame(1, i, 1'b0, 1'b0, 0);
      end
      hold_bits(1, 1);
      check_status("overflow", 1);
      set_load(1, 1'b0);
      check_done("overflow", 1);

      set_load(1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         int d;
         d  = $urandom_range(0, 255);
         bp = ($urandom_range(0, 9) < 3);
         model_frame(1, d, bp, 1'b0);
         send_frame(1, d, bp, 1'b0, $urandom_range(0, 2));
      end
      hold_bits(1, 1);
      check_status("rand_b", 1);
      set_load(1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Parametrised UART program loader that sits between the serial `RX` pin and the CPU program/data memory write port. While `Load` is high it receives frames with configurable width, parity and stop bits, validates each frame, and writes accepted words to sequential addresses starting at 0. It reports framing, parity and overflow errors, and pulses `Done` when loading ends. It generalises the fixed 8N1, 5-bit-address loader path with width, depth, parity, stop-bit, error and status features.

## Interface
- `BAUD_DIV`, 24: clock cycles per bit; must be an even number of at least 4.
- `DATA_W`, 8: data bits per frame, 5 to 9.
- `ADDR_W`, 5: memory address width; depth is 2^ADDR_W.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Load`  in  1  load window enable; level-sensitive.
- `RX`  in  1  serial input; idles high; asynchronous to `Clk`.
- `Wr_en`  out  1  one-cycle memory write strobe.
- `Wr_addr`  out  ADDR_W  write address.
- `Wr_data`  out  DATA_W  write data.
- `Byte_count`  out  ADDR_W+1  number of words written in the current window.
- `Busy`  out  1  high while a frame is in progress.
- `Done`  out  1  one-cycle pulse when the load window ends.
- `FE`  out  1  sticky framing error.
- `PE`  out  1  sticky parity error.
- `Overflow`  out  1  sticky flag: a valid word arrived while memory was full.

## Operation
- **Reset.** All outputs are 0. The counters are 0. The FSM is in IDLE. The synchroniser flops are set to 1.
- **RX synchronisation.** `RX` passes through a 2-flop synchroniser. All decisions use the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
  - IDLE: on `Load`=1 and `rxs`=0, go to START and load the bit timer with BAUD_DIV/2−1.
  - START: at timer expiry, sample `rxs`.
    - If 1, it was a glitch: return to IDLE with no flags set.
    - If 0, go to DATA with timer BAUD_DIV−1.
  - DATA: take DATA_W samples, one every BAUD_DIV cycles, LSB first, into a shift register. Then go to PAR if PARITY≠0, otherwise to STOP.
  - PAR: take one sample and compare it with the XOR of the data bits.
    - Even parity: the sample must equal the XOR.
    - Odd parity: the sample must equal the inverted XOR.
    - A mismatch marks the frame bad-parity.
  - STOP: take STOP_BITS samples.
    - Any 0 sample sets `FE`, discards the frame and goes to WAIT_HIGH.
    - Otherwise the frame completes and the FSM returns to IDLE.
  - WAIT_HIGH: go to IDLE on the first `rxs`=1.
- **Frame acceptance.** A frame is accepted only if the start bit is valid, parity is good and all stop bits are good.
  - Bad parity: set `PE` and do not write.
- **Write.** For each accepted frame:
  - If `Byte_count` < 2^ADDR_W: pulse `Wr_en` with `Wr_addr` = `Byte_count[ADDR_W-1:0]` and `Wr_data` = the shift register, then increment `Byte_count`.
  - Otherwise: set `Overflow`, do not write, and leave the count unchanged.
- **Rising edge of `Load`.** Clears `Byte_count`, `FE`, `PE` and `Overflow` on the same cycle.
- **`Load` falls.**
  - The FSM aborts to IDLE immediately and any partial frame is discarded without setting flags.
  - `Done` pulses for one cycle.
  - `Byte_count` and the flags hold until the next rising edge of `Load`.
- **`Busy`** is 1 when the state is not IDLE.
- **`Wr_addr` and `Wr_data`** hold their last written values between strobes.
- **Reset mid-frame** forces the full reset state. No `Wr_en` or `Done` pulse is produced.

## Timing
- The synchroniser adds 2 cycles.
- **Write latency.** Let t0 be the first `Clk` edge that samples `RX`=0. `Wr_en` is high on cycle t0 + 2 + BAUD_DIV/2 + (DATA_W + P + STOP_BITS)·BAUD_DIV + 1, where P = (PARITY≠0).
- **Idle gap.** The FSM is back in IDLE one cycle after the final stop sample. A start bit that immediately follows the stop bit(s) is captured with no lost frames.
- **Flag timing.** `FE` and `PE` assert on the cycle that `Wr_en` would have asserted.
- **`Done` timing.** `Done` is high on the cycle after `Load` is sampled low while the previous sample was high.
- **`Load` rising on the same edge as frame completion.** The clear wins and the completed frame is dropped. This can only happen when `Load` toggles low then high within one frame.
- **Counter width.** `Byte_count` saturates at 2^ADDR_W. It never wraps, and `Wr_addr` never wraps back to 0.

## Test plan
- **Normal load.** Defaults, BAUD_DIV=24. Send C0, 40, A3, E5, A0, 00 (8N1). Expect six `Wr_en` pulses at addresses 0–5 with matching data. Expect `Byte_count`=6 and FE=PE=Overflow=0. Expect a `Done` pulse after `Load` falls.
- **Framing error.** Send A3 with the stop bit held at 0 for one bit time, then 55 normally. Expect FE=1, no write for A3, and 55 written at address 0.
- **Parity.** Set PARITY=2. Send E5 with a correct parity bit (0): written. Send E5 with parity bit 1: PE=1 and no write. `Byte_count`=1.
- **Overflow.** Set ADDR_W=2. Send 01, 02, 03, 04, 05. Expect writes at addresses 0–3, Overflow=1 after the fifth frame, and `Byte_count`=4.
- **Glitch and abort.**
  - Drive `RX` low for 5 cycles: expect no state change beyond START and no flags.
  - Drop `Load` mid-data-bit: expect IDLE the next cycle, no write, and a `Done` pulse.
- **Reset and reload.**
  - Assert `Reset_n`=0 mid-frame: all outputs go to 0 asynchronously.
  - Raise `Load` again after a window that ended with FE=1: FE clears and the count restarts at 0.
